// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - memory-op codes, FSM states and decode helpers for mem_stage
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_OP_LB   = 4'd0,
        MEM_OP_LH   = 4'd1,
        MEM_OP_LW   = 4'd2,
        MEM_OP_LBU  = 4'd3,
        MEM_OP_LHU  = 4'd4,
        MEM_OP_SB   = 4'd5,
        MEM_OP_SH   = 4'd6,
        MEM_OP_SW   = 4'd7,
        MEM_OP_NONE = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ZERO          = 32'h0;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;

    function automatic logic is_load(input logic [3:0] op);
        return (op == MEM_OP_LB) || (op == MEM_OP_LH) || (op == MEM_OP_LW) ||
               (op == MEM_OP_LBU) || (op == MEM_OP_LHU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one; bytes never misalign.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: return off[0];
            MEM_OP_LW, MEM_OP_SW:             return off != 2'b00;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - req/gnt/rvalid data-bus interface
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane replication / byte enables and load extraction
module mem_lane_align
    import mem_stage_pkg::*;
(
    input  logic [3:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [3:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Byte enables and replicated write data for the op currently presented upstream.
    always_comb begin
        be    = 4'b0000;
        wdata = st_data;
        case (st_op)
            MEM_OP_SB: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            MEM_OP_SH: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            MEM_OP_SW, MEM_OP_LB, MEM_OP_LH, MEM_OP_LW, MEM_OP_LBU, MEM_OP_LHU: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Lane selection uses the offset latched at request time, not the live address.
    always_comb begin
        case (ld_off)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_op)
            MEM_OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            MEM_OP_LBU: ld_data = {24'h0, ld_byte};
            MEM_OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
            MEM_OP_LHU: ld_data = {16'h0, ld_half};
            default:    ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with req/gnt/rvalid bus and MEM/WB slot
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [DATA_WIDTH-1:0]  reg_wdata_i,
    input  logic                   mem_we_i,
    input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
    input  logic [DATA_WIDTH-1:0]  mem_data_i,
    input  logic [3:0]             mem_op_i,
    mem_stage_if.master            dbus,
    output logic                   stall_o,
    output logic                   misalign_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [DATA_WIDTH-1:0]  reg_wdata_o
);

    state_e                 state, state_nxt;
    logic [3:0]             op_q;
    logic [1:0]             off_q;
    logic [RADDR_WIDTH-1:0] waddr_q;
    logic                   we_q;

    logic                   op_mem, op_st, misal, req;
    logic [3:0]             be_w;
    logic [DATA_WIDTH-1:0]  wdata_w, ld_data;

    // mem_op_i is authoritative for direction; the store flag is redundant.
    logic unused_ok;
    assign unused_ok = mem_we_i;

    assign op_st  = is_store(mem_op_i);
    assign op_mem = is_load(mem_op_i) || op_st;
    assign misal  = op_mem && is_misaligned(mem_op_i, mem_addr_i[1:0]);

    mem_lane_align u_align (
        .st_op   (mem_op_i),
        .st_off  (mem_addr_i[1:0]),
        .st_data (mem_data_i),
        .be      (be_w),
        .wdata   (wdata_w),
        .ld_op   (op_q),
        .ld_off  (off_q),
        .rdata   (dbus.rdata),
        .ld_data (ld_data)
    );

    // Bus fields come straight from the held upstream inputs while a request is live.
    assign dbus.req   = req;
    assign dbus.we    = req && op_st;
    assign dbus.addr  = {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
    assign dbus.be    = req ? be_w : 4'b0000;
    assign dbus.wdata = wdata_w;

    // Next state, bus request and stall; stall drops in the completion cycle.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        stall_o   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (op_mem && !misal) begin
                    req     = 1'b1;
                    stall_o = !(op_st && dbus.gnt);
                    if (!dbus.gnt)
                        state_nxt = ST_REQ;
                    else if (!op_st)
                        state_nxt = ST_RESP;
                end
            end
            ST_REQ: begin
                req     = 1'b1;
                stall_o = !(is_store(op_q) && dbus.gnt);
                if (dbus.gnt)
                    state_nxt = is_store(op_q) ? ST_IDLE : ST_RESP;
            end
            ST_RESP: begin
                stall_o = !dbus.rvalid;
                if (dbus.rvalid)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Capture the access context on the cycle a new request is issued from IDLE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q    <= MEM_OP_NONE;
            off_q   <= 2'b00;
            waddr_q <= '0;
            we_q    <= WRITE_DISABLE;
        end else if (state == ST_IDLE && req) begin
            op_q    <= mem_op_i;
            off_q   <= mem_addr_i[1:0];
            waddr_q <= reg_waddr_i;
            we_q    <= reg_we_i;
        end
    end

    // MEM/WB result slot: bubble on stall, misalign pulse, otherwise the completing result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            reg_waddr_o <= '0;
            reg_we_o    <= WRITE_DISABLE;
            reg_wdata_o <= ZERO[DATA_WIDTH-1:0];
            misalign_o  <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            if (stall_o) begin
                reg_we_o <= WRITE_DISABLE;
            end else if (state == ST_IDLE && misal) begin
                misalign_o <= 1'b1;
                reg_we_o   <= WRITE_DISABLE;
            end else if (state == ST_RESP) begin
                reg_waddr_o <= waddr_q;
                reg_we_o    <= we_q;
                reg_wdata_o <= ld_data;
            end else if (state == ST_REQ) begin
                reg_waddr_o <= waddr_q;
                reg_we_o    <= we_q;
                reg_wdata_o <= reg_wdata_i;
            end else begin
                reg_waddr_o <= reg_waddr_i;
                reg_we_o    <= reg_we_i;
                reg_wdata_o <= reg_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [3:0]  mem_op_i;
    logic        stall_o;
    logic        misalign_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;

    int n_assert = 0;
    int n_fail   = 0;

    mem_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dbus ();

    mem_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .mem_we_i    (mem_we_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_op_i    (mem_op_i),
        .dbus        (dbus.master),
        .stall_o     (stall_o),
        .misalign_o  (misalign_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] waddr, input logic we, input logic [31:0] wdata);
        mem_op_i    = op;
        mem_we_i    = is_store(op);
        mem_addr_i  = addr;
        mem_data_i  = data;
        reg_waddr_i = waddr;
        reg_we_i    = we;
        reg_wdata_i = wdata;
    endtask

    initial begin
        rst_i = 1'b1;
        dbus.gnt = 1'b0; dbus.rvalid = 1'b0; dbus.rdata = 32'h0;
        drive(MEM_OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        check("rst_we", {31'b0, reg_we_o}, 32'h0);
        check("rst_wdata", reg_wdata_o, 32'h0);
        check("rst_misalign", {31'b0, misalign_o}, 32'h0);
        check("rst_req", {31'b0, dbus.req}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // ALU pass-through
        @(posedge clk_i); #1;
        drive(MEM_OP_NONE, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234);
        #1;
        check("pass_stall", {31'b0, stall_o}, 32'h0);
        check("pass_req", {31'b0, dbus.req}, 32'h0);
        @(posedge clk_i); #1;
        check("pass_waddr", {27'b0, reg_waddr_o}, 32'd5);
        check("pass_we", {31'b0, reg_we_o}, 32'h1);
        check("pass_wdata", reg_wdata_o, 32'h1234);

        // SB with immediate grant
        drive(MEM_OP_SB, 32'h1003, 32'h0000_00AB, 5'd0, 1'b0, 32'h0);
        dbus.gnt = 1'b1;
        #1;
        check("sb_req", {31'b0, dbus.req}, 32'h1);
        check("sb_we", {31'b0, dbus.we}, 32'h1);
        check("sb_be", {28'b0, dbus.be}, 32'h8);
        check("sb_wdata", dbus.wdata, 32'hABAB_ABAB);
        check("sb_addr", dbus.addr, 32'h1000);
        check("sb_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        check("sb_reg_we", {31'b0, reg_we_o}, 32'h0);

        // SH upper half with immediate grant
        drive(MEM_OP_SH, 32'h1006, 32'h1234_CDEF, 5'd0, 1'b0, 32'h0);
        #1;
        check("sh_be", {28'b0, dbus.be}, 32'hC);
        check("sh_wdata", dbus.wdata, 32'hCDEF_CDEF);
        check("sh_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;

        // SW granted one cycle late
        drive(MEM_OP_SW, 32'h1008, 32'h1122_3344, 5'd0, 1'b0, 32'h0);
        dbus.gnt = 1'b0;
        #1;
        check("sw_stall0", {31'b0, stall_o}, 32'h1);
        @(posedge clk_i); #1;
        dbus.gnt = 1'b1;
        #1;
        check("sw_req1", {31'b0, dbus.req}, 32'h1);
        check("sw_be", {28'b0, dbus.be}, 32'hF);
        check("sw_wdata", dbus.wdata, 32'h1122_3344);
        check("sw_stall1", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        check("sw_reg_we", {31'b0, reg_we_o}, 32'h0);

        // LB with gnt after 2 cycles, rvalid one cycle later
        drive(MEM_OP_LB, 32'h2001, 32'h0, 5'd7, 1'b1, 32'h0);
        dbus.gnt = 1'b0;
        #1;
        check("lb_stall_c1", {31'b0, stall_o}, 32'h1);
        check("lb_req_c1", {31'b0, dbus.req}, 32'h1);
        check("lb_be", {28'b0, dbus.be}, 32'hF);
        check("lb_buswe", {31'b0, dbus.we}, 32'h0);
        check("lb_addr", dbus.addr, 32'h2000);
        @(posedge clk_i); #1;
        check("lb_bubble1", {31'b0, reg_we_o}, 32'h0);
        check("lb_stall_c2", {31'b0, stall_o}, 32'h1);
        check("lb_req_c2", {31'b0, dbus.req}, 32'h1);
        @(posedge clk_i); #1;
        check("lb_bubble2", {31'b0, reg_we_o}, 32'h0);
        dbus.gnt = 1'b1;
        #1;
        check("lb_stall_c3", {31'b0, stall_o}, 32'h1);
        @(posedge clk_i); #1;
        check("lb_bubble3", {31'b0, reg_we_o}, 32'h0);
        dbus.gnt = 1'b0; dbus.rvalid = 1'b1; dbus.rdata = 32'h0000_8000;
        #1;
        check("lb_resp_req", {31'b0, dbus.req}, 32'h0);
        check("lb_resp_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        check("lb_we", {31'b0, reg_we_o}, 32'h1);
        check("lb_waddr", {27'b0, reg_waddr_o}, 32'd7);
        check("lb_wdata", reg_wdata_o, 32'hFFFF_FF80);

        // LHU with immediate grant, zero-extended upper half
        dbus.rvalid = 1'b0;
        drive(MEM_OP_LHU, 32'h2002, 32'h0, 5'd9, 1'b1, 32'h0);
        dbus.gnt = 1'b1;
        #1;
        check("lhu_stall", {31'b0, stall_o}, 32'h1);
        @(posedge clk_i); #1;
        dbus.gnt = 1'b0; dbus.rvalid = 1'b1; dbus.rdata = 32'hBEEF_0000;
        #1;
        check("lhu_resp_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        check("lhu_we", {31'b0, reg_we_o}, 32'h1);
        check("lhu_waddr", {27'b0, reg_waddr_o}, 32'd9);
        check("lhu_wdata", reg_wdata_o, 32'h0000_BEEF);

        // Misaligned LW
        dbus.rvalid = 1'b0;
        drive(MEM_OP_LW, 32'h3002, 32'h0, 5'd4, 1'b1, 32'h0);
        #1;
        check("mis_req", {31'b0, dbus.req}, 32'h0);
        check("mis_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        check("mis_pulse", {31'b0, misalign_o}, 32'h1);
        check("mis_we", {31'b0, reg_we_o}, 32'h0);
        drive(MEM_OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(posedge clk_i); #1;
        check("mis_drop", {31'b0, misalign_o}, 32'h0);

        // Reset while in RESP, then a stray rvalid afterwards
        drive(MEM_OP_NONE, 32'h0, 32'h0, 5'd3, 1'b1, 32'h55);
        @(posedge clk_i); #1;
        check("pre_rst_we", {31'b0, reg_we_o}, 32'h1);
        drive(MEM_OP_LW, 32'h4000, 32'h0, 5'd3, 1'b1, 32'h0);
        dbus.gnt = 1'b1;
        @(posedge clk_i); #1;
        dbus.gnt = 1'b0;
        #1;
        check("resp_stall", {31'b0, stall_o}, 32'h1);
        rst_i = 1'b1;
        drive(MEM_OP_NONE, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        #1;
        check("mid_rst_wdata", reg_wdata_o, 32'h0);
        check("mid_rst_waddr", {27'b0, reg_waddr_o}, 32'h0);
        check("mid_rst_stall", {31'b0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dbus.rvalid = 1'b1; dbus.rdata = 32'hDEAD_BEEF;
        #1;
        check("late_rv_stall", {31'b0, stall_o}, 32'h0);
        check("late_rv_req", {31'b0, dbus.req}, 32'h0);
        @(posedge clk_i); #1;
        check("late_rv_we", {31'b0, reg_we_o}, 32'h0);
        check("late_rv_wdata", reg_wdata_o, 32'h0);
        dbus.rvalid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
